// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path.
// FSM state encodings used by uart_receiver.
package uart_receiver_pkg;

  localparam int NB_STATE = 3;

  typedef enum logic [NB_STATE-1:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/uart_receiver_baud_rate_generator.sv
// Free-running oversampling tick generator.
// One-cycle o_tick each time the divider wraps.
module baud_rate_generator #(
  parameter int BAUD_DIVISOR = 651,
  parameter int NB_DIVISOR   = 10
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam logic [NB_DIVISOR-1:0] LAST =
    NB_DIVISOR'(BAUD_DIVISOR - 1);

  logic [NB_DIVISOR-1:0] r_cnt;
  logic                  w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign o_tick = w_wrap;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling.
// Emits one-cycle o_rx_done / o_frame_error pulses.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int NB_DATA      = 8,
  parameter int N_TICKS      = 16,
  parameter int BAUD_DIVISOR = 651,
  parameter int NB_DIVISOR   = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_error
);

  localparam int NB_TCNT =
    (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
  localparam int NB_BCNT =
    (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_TCNT-1:0] T_MID =
    NB_TCNT'(N_TICKS / 2 - 1);
  localparam logic [NB_TCNT-1:0] T_END =
    NB_TCNT'(N_TICKS - 1);
  localparam logic [NB_BCNT-1:0] B_END =
    NB_BCNT'(NB_DATA - 1);

  logic               w_tick;
  logic               r_rx_meta;
  logic               r_rx_s;
  state_t             r_state;
  logic [NB_TCNT-1:0] r_tick_cnt;
  logic [NB_BCNT-1:0] r_bit_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic [NB_DATA-1:0] r_rx_data;
  logic               r_rx_done;
  logic               r_frame_error;

  baud_rate_generator #(
    .BAUD_DIVISOR (BAUD_DIVISOR),
    .NB_DIVISOR   (NB_DIVISOR)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  // Two-stage synchroniser; resets to the idle level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_tick_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_rx_done     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_rx_done     <= 1'b0;
      r_frame_error <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == T_MID) begin
              if (!r_rx_s) begin
                r_state    <= DATA;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == T_END) begin
              r_shift    <= {r_rx_s, r_shift[NB_DATA-1:1]};
              r_tick_cnt <= '0;
              if (r_bit_cnt == B_END) begin
                r_state <= STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == T_END) begin
              r_tick_cnt <= '0;
              if (r_rx_s) begin
                r_rx_data <= r_shift;
                r_rx_done <= 1'b1;
                r_state   <= IDLE;
              end else begin
                r_frame_error <= 1'b1;
                r_state       <= WAIT_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        WAIT_IDLE: begin
          if (r_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_rx_data     = r_rx_data;
  assign o_rx_done     = r_rx_done;
  assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver.
// Frame-level reference model with an event queue.
module tb_uart_receiver;

  localparam int DIV = 4;
  localparam int NT  = 16;
  localparam int BIT = DIV * NT;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_rx_data;
  logic       o_rx_done;
  logic       o_frame_error;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;

  // Expected events: bit 8 = framing error, [7:0] = byte.
  logic [8:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;

  always #5 clk = ~clk;

  uart_receiver #(
    .NB_DATA      (8),
    .N_TICKS      (NT),
    .BAUD_DIVISOR (DIV),
    .NB_DIVISOR   (10)
  ) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_rx          (i_rx),
    .o_rx_data     (o_rx_data),
    .o_rx_done     (o_rx_done),
    .o_frame_error (o_frame_error)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Compare process: every post-reset cycle.
  always @(negedge clk) begin
    logic [8:0] e;
    if (i_reset) begin
      exp_data = 8'h00;
      exp_q.delete();
    end else begin
      chk("pulse_overlap",
          {31'd0, o_rx_done & o_frame_error}, 32'd0);
      if (o_rx_done) done_cnt++;
      if (o_frame_error) ferr_cnt++;
      if (o_rx_done || o_frame_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse",
              {30'd0, o_frame_error, o_rx_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {31'd0, o_frame_error},
              {31'd0, e[8]});
          if (!e[8]) exp_data = e[7:0];
        end
      end
      chk("rx_data", {24'd0, o_rx_data}, {24'd0, exp_data});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stop_ok);
    exp_q.push_back({~stop_ok, d});
    i_rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      cyc(BIT);
    end
    i_rx = stop_ok;
    cyc(BIT);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10 * BIT) begin
      cyc(1);
      n++;
    end
    chk(nm, exp_q.size(), 32'd0);
  endtask

  initial begin
    int d0;
    int f0;
    logic [7:0] rb;
    logic bad;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    cyc(3);
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_data", {24'd0, o_rx_data}, 32'h00);
    chk("reset_done", {31'd0, o_rx_done}, 32'd0);
    chk("reset_ferr", {31'd0, o_frame_error}, 32'd0);
    cyc(20 * BIT);
    chk("idle_no_pulse", done_cnt + ferr_cnt, 32'd0);

    // Single frame
    send(8'h55, 1'b1);
    drain("drain_55");
    chk("lit_55", {24'd0, o_rx_data}, 32'h55);
    chk("cnt_55", done_cnt, 32'd1);

    // Back-to-back, no idle between frames
    d0 = done_cnt;
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    send(8'hCC, 1'b1);
    send(8'hDD, 1'b1);
    drain("drain_b2b");
    chk("cnt_b2b", done_cnt - d0, 32'd4);
    cyc(2 * BIT);
    chk("lit_dd", {24'd0, o_rx_data}, 32'hDD);

    // Short glitch must be rejected
    d0 = done_cnt;
    i_rx = 1'b0;
    cyc(16);
    i_rx = 1'b1;
    cyc(3 * BIT);
    chk("glitch_no_done", done_cnt - d0, 32'd0);
    send(8'h01, 1'b1);
    drain("drain_01");
    chk("lit_01", {24'd0, o_rx_data}, 32'h01);

    // Framing error, line stuck low
    d0 = done_cnt;
    f0 = ferr_cnt;
    send(8'hFF, 1'b0);
    cyc(5 * BIT);
    i_rx = 1'b1;
    cyc(BIT);
    drain("drain_ferr");
    chk("ferr_cnt", ferr_cnt - f0, 32'd1);
    chk("ferr_no_done", done_cnt - d0, 32'd0);
    chk("lit_keep_01", {24'd0, o_rx_data}, 32'h01);
    send(8'h1F, 1'b1);
    drain("drain_1f");
    chk("lit_1f", {24'd0, o_rx_data}, 32'h1F);

    // Reset in the middle of data bit 4 of 8'h3C
    d0 = done_cnt;
    f0 = ferr_cnt;
    rb = 8'h3C;
    i_rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      i_rx = rb[i];
      cyc(BIT);
    end
    i_rx = rb[4];
    cyc(BIT / 2);
    i_reset = 1'b1;
    cyc(2);
    i_reset = 1'b0;
    i_rx = 1'b1;
    cyc(3 * BIT);
    chk("rst_no_pulse", (done_cnt - d0) + (ferr_cnt - f0), 32'd0);
    chk("lit_rst_zero", {24'd0, o_rx_data}, 32'h00);
    send(8'h3C, 1'b1);
    drain("drain_3c");
    chk("lit_3c", {24'd0, o_rx_data}, 32'h3C);

    // Randomised frames, gaps and framing errors
    for (int k = 0; k < 16; k++) begin
      rb  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send(rb, ~bad);
      if (bad) begin
        cyc($urandom_range(0, 2 * BIT));
        i_rx = 1'b1;
        cyc(BIT);
      end else begin
        cyc($urandom_range(0, 40));
      end
    end
    drain("drain_rand");
    cyc(2 * BIT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
